pc_fetch_unit: RTL and testbench

Program-counter register and instruction-fetch sequencer for the 8-bit MIPS core. Holds the current PC, drives it to the PC incrementer and instruction memory, and loads the incremented address back after each completed fetch. Handles branch/jump redirects and the req/ack handshake with instruction memory. Presents fetched instructions to decode with a valid/ready handshake.

---
 rtl/pc_fetch_unit.sv | 110 +++++++++++
 tb/tb_pc_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer: IDLE -> FETCH (req/ack with imem)
// -> WAIT_DEC (valid/ready with decode), with jump/branch redirects in any state.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc_plus1,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [1:0]         state
);

  // Handshakes: imem transfer happens on a cycle with imem_req=1 and imem_ack=1;
  // decode transfer happens on a cycle with instr_valid=1 and instr_ready=1.
  // A redirect in the same cycle overrides either transfer.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_DEC = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_d;
  logic               req_d;
  logic [INSTR_W-1:0] instr_d;
  logic               valid_d;

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_out      <= RESET_PC;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_out      <= pc_d;
      imem_req    <= req_d;
      instr       <= instr_d;
      instr_valid <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_out;
    req_d   = imem_req;
    instr_d = instr;
    valid_d = instr_valid;
    if (jump || branch_taken) begin
      // Flush and restart from the target; jump outranks branch.
      pc_d    = jump ? jump_target : branch_target;
      valid_d = 1'b0;
      req_d   = 1'b0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          req_d   = 1'b1;
          state_d = FETCH;
        end
        FETCH: begin
          if (imem_req && imem_ack) begin
            instr_d = imem_data;
            valid_d = 1'b1;
            pc_d    = pc_plus1;
            req_d   = 1'b0;
            state_d = WAIT_DEC;
          end
        end
        WAIT_DEC: begin
          if (instr_valid && instr_ready) begin
            valid_d = 1'b0;
            req_d   = 1'b1;
            state_d = FETCH;
          end
        end
        default: begin
          req_d   = 1'b0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // The external incrementer must agree with the PC whenever its result is loaded.
  property p_incr_ok;
    @(posedge clk) disable iff (!rst_n)
      (state_q == FETCH && imem_req && imem_ack && !jump && !branch_taken)
        |-> (pc_plus1 == ADDR_W'(pc_out + 1'b1));
  endproperty
  a_incr_ok: assert property (p_incr_ok);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed vector bench for pc_fetch_unit: table of per-cycle stimulus and
// expected registered outputs, plus a hand-written asynchronous reset sequence.
module tb_pc_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pc_plus1;
  logic [7:0] pc_out;
  logic       imem_req;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic       jump;
  logic [7:0] jump_target;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  typedef struct {
    logic       j;
    logic [7:0] jt;
    logic       b;
    logic [7:0] bt;
    logic       ack;
    logic [7:0] data;
    logic       rdy;
    logic [7:0] e_pc;
    logic       e_req;
    logic [7:0] e_instr;
    logic       e_valid;
    logic [1:0] e_st;
  } vec_t;

  vec_t vq[$];

  pc_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pc_plus1(pc_plus1),
    .pc_out(pc_out),
    .imem_req(imem_req),
    .imem_ack(imem_ack),
    .imem_data(imem_data),
    .jump(jump),
    .jump_target(jump_target),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .state(state)
  );

  // Clock / reset block; the bench acts as the PC incrementer.
  always #5 clk = ~clk;
  assign pc_plus1 = pc_out + 8'd1;

  initial begin
    #20000;
    $display("FAIL watchdog: got no end of test, required finish before 20000");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  task automatic v(input logic j, input logic [7:0] jt, input logic b, input logic [7:0] bt,
                   input logic ack, input logic [7:0] data, input logic rdy,
                   input logic [7:0] e_pc, input logic e_req, input logic [7:0] e_instr,
                   input logic e_valid, input logic [1:0] e_st);
    vec_t r;
    r.j = j; r.jt = jt; r.b = b; r.bt = bt; r.ack = ack; r.data = data; r.rdy = rdy;
    r.e_pc = e_pc; r.e_req = e_req; r.e_instr = e_instr; r.e_valid = e_valid; r.e_st = e_st;
    vq.push_back(r);
  endtask

  task automatic check(input string name, input logic [7:0] e_pc, input logic e_req,
                       input logic [7:0] e_instr, input logic e_valid, input logic [1:0] e_st);
    tests_run++;
    if ({pc_out, imem_req, instr, instr_valid, state} !== {e_pc, e_req, e_instr, e_valid, e_st}) begin
      tests_failed++;
      $display("FAIL %s: got pc=%h req=%b instr=%h valid=%b state=%0d, required pc=%h req=%b instr=%h valid=%b state=%0d",
               name, pc_out, imem_req, instr, instr_valid, state, e_pc, e_req, e_instr, e_valid, e_st);
    end
  endtask

  task automatic drive_idle();
    jump = 0; jump_target = 0; branch_taken = 0; branch_target = 0;
    imem_ack = 0; imem_data = 0; instr_ready = 0;
  endtask

  task automatic run_vec(input vec_t r, input int idx);
    jump = r.j; jump_target = r.jt; branch_taken = r.b; branch_target = r.bt;
    imem_ack = r.ack; imem_data = r.data; instr_ready = r.rdy;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", idx), r.e_pc, r.e_req, r.e_instr, r.e_valid, r.e_st);
  endtask

  task automatic step(input string name, input logic ack, input logic [7:0] data,
                      input logic [7:0] e_pc, input logic e_req, input logic [7:0] e_instr,
                      input logic e_valid, input logic [1:0] e_st);
    imem_ack = ack; imem_data = data; instr_ready = 1'b1;
    @(posedge clk);
    #1;
    check(name, e_pc, e_req, e_instr, e_valid, e_st);
  endtask

  initial begin
    // Memory answers one cycle after it sees the request (3-cycle throughput).
    // Sequential fetch from reset, decode always ready.
    v(0,0,0,0, 0,8'h00,1, 8'h00,1,8'h00,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'h00,1,8'h00,0,S_FETCH);
    v(0,0,0,0, 1,8'hA0,1, 8'h01,0,8'hA0,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,1, 8'h01,1,8'hA0,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'h01,1,8'hA0,0,S_FETCH);
    v(0,0,0,0, 1,8'hA1,1, 8'h02,0,8'hA1,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,1, 8'h02,1,8'hA1,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'h02,1,8'hA1,0,S_FETCH);
    v(0,0,0,0, 1,8'hA2,1, 8'h03,0,8'hA2,1,S_WAIT);
    // Wrap-around through FF -> 00; ready during the jump is ignored.
    v(1,8'hFE,0,0, 0,8'h00,1, 8'hFE,0,8'hA2,0,S_IDLE);
    v(0,0,0,0, 0,8'h00,1, 8'hFE,1,8'hA2,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'hFE,1,8'hA2,0,S_FETCH);
    v(0,0,0,0, 1,8'h9E,1, 8'hFF,0,8'h9E,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,1, 8'hFF,1,8'h9E,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'hFF,1,8'h9E,0,S_FETCH);
    v(0,0,0,0, 1,8'h9F,1, 8'h00,0,8'h9F,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,1, 8'h00,1,8'h9F,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'h00,1,8'h9F,0,S_FETCH);
    v(0,0,0,0, 1,8'hA0,1, 8'h01,0,8'hA0,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,1, 8'h01,1,8'hA0,0,S_FETCH);
    // Memory wait states at PC 05: four cycles without ack.
    v(1,8'h05,0,0, 0,8'h00,1, 8'h05,0,8'hA0,0,S_IDLE);
    v(0,0,0,0, 0,8'h00,1, 8'h05,1,8'hA0,0,S_FETCH);
    for (int i = 0; i < 4; i++)
      v(0,0,0,0, 0,8'h00,1, 8'h05,1,8'hA0,0,S_FETCH);
    v(0,0,0,0, 1,8'h3C,0, 8'h06,0,8'h3C,1,S_WAIT);
    // Decode backpressure for five cycles; a stray ack with req low is ignored.
    v(0,0,0,0, 0,8'h00,0, 8'h06,0,8'h3C,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,0, 8'h06,0,8'h3C,1,S_WAIT);
    v(0,0,0,0, 1,8'hFF,0, 8'h06,0,8'h3C,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,0, 8'h06,0,8'h3C,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,0, 8'h06,0,8'h3C,1,S_WAIT);
    v(0,0,0,0, 0,8'h00,1, 8'h06,1,8'h3C,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'h06,1,8'h3C,0,S_FETCH);
    // Branch coincident with ack: data dropped, refetch from 40.
    v(0,0,1,8'h40, 1,8'h77,1, 8'h40,0,8'h3C,0,S_IDLE);
    v(0,0,0,0, 0,8'h00,1, 8'h40,1,8'h3C,0,S_FETCH);
    v(0,0,0,0, 0,8'h00,1, 8'h40,1,8'h3C,0,S_FETCH);
    v(0,0,0,0, 1,8'hE0,1, 8'h41,0,8'hE0,1,S_WAIT);
    // Jump beats branch; ready in that cycle does not deliver.
    v(1,8'h80,1,8'h40, 0,8'h00,1, 8'h80,0,8'hE0,0,S_IDLE);
    v(0,0,0,0, 0,8'h00,1, 8'h80,1,8'hE0,0,S_FETCH);
    // Back-to-back redirects: the last one wins.
    v(0,0,1,8'h20, 0,8'h00,1, 8'h20,0,8'hE0,0,S_IDLE);
    v(1,8'h30,0,0, 0,8'h00,1, 8'h30,0,8'hE0,0,S_IDLE);
    v(0,0,0,0, 0,8'h00,1, 8'h30,1,8'hE0,0,S_FETCH);
    // Move to PC 12 in FETCH for the reset sequence.
    v(1,8'h12,0,0, 0,8'h00,1, 8'h12,0,8'hE0,0,S_IDLE);
    v(0,0,0,0, 0,8'h00,1, 8'h12,1,8'hE0,0,S_FETCH);

    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_values", 8'h00, 0, 8'h00, 0, S_IDLE);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      run_vec(vq[i], i);

    // Asynchronous reset mid-fetch, sampled before any further clock edge.
    drive_idle();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'h00, 0, 8'h00, 0, S_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step("restart_fetch", 0, 8'h00, 8'h00, 1, 8'h00, 0, S_FETCH);
    step("restart_wait",  0, 8'h00, 8'h00, 1, 8'h00, 0, S_FETCH);
    step("restart_ack",   1, 8'hA0, 8'h01, 0, 8'hA0, 1, S_WAIT);
    step("restart_next",  0, 8'h00, 8'h01, 1, 8'hA0, 0, S_FETCH);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
